pwr_seq: RTL and testbench
==========================

Name: pwr_seq

Overview:
- Power/reset sequencer directly upstream of the SoC wrapper.
- Turns the board reset, UART CTS wake and DFU strap into a clean, stretched, active-low SoC reset plus a latched boot-mode bit.
- Handles poweroff requests: drains UART TX, then enforces a minimum off time before the next wake is accepted.
- Replaces ad-hoc wake logic with debounced, counted, observable sequencing.

Parameters:
- WAKE_CYCLES, 16: consecutive synchronized cycles of uart_cts low needed to accept a wake.
- RST_CYCLES, 32: cycles soc_resetn is held low after a wake is accepted.
- DRAIN_CYCLES, 64: consecutive cycles of uart_tx high needed before power-off completes.
- COOLDOWN_CYCLES, 256: minimum cycles spent in OFF-side cooldown before a new wake is evaluated.
- CNT_W, 16: width of the shared down-counter. Elaboration fails if any *_CYCLES is ≥ 2^CNT_W or < 1.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- uart_cts  in  1  async wake pin, active low
- dfu  in  1  async boot-mode strap
- uart_tx  in  1  SoC UART TX, observed for drain
- poweroff_rq  in  1  SoC poweroff request, level
- wdt_kick  in  1  SoC watchdog kick pulse (present only with PWRSEQ_WDT_EN)
- soc_resetn  out  1  active-low reset to SoC
- running  out  1  high in RUN and DRAIN; gates UART outputs downstream
- dfu_mode  out  1  dfu value latched at wake acceptance
- wake_count  out  8  accepted wakes, wraps 255→0
- wdt_fired  out  1  sticky watchdog-expiry flag (tied 0 without PWRSEQ_WDT_EN)

Behaviour:
- uart_cts and dfu pass through 2-flop synchronizers (reset value 1 and 0); all decisions use the synchronized values (2-cycle input latency).
- Reset (async assert): state=OFF, cnt=WAKE_CYCLES-1, soc_resetn=0, running=0, dfu_mode=0, wake_count=0, wdt_fired=0.
- Deassertion is used as-is; the upstream board logic provides a synchronous release.
- States and counter usage:
  - OFF: cnt counts down while cts_s==0; reloads WAKE_CYCLES-1 on any cts_s==1 cycle. If cnt==0 with cts_s==0 → RST_HOLD; cnt=RST_CYCLES-1; dfu_mode<=dfu_s; wake_count++.
  - RST_HOLD: soc_resetn=0; cnt decrements; at cnt==0 → RUN.
  - RUN: soc_resetn=1, running=1. poweroff_rq==1 → DRAIN; cnt=DRAIN_CYCLES-1. soc_resetn stays 1 during DRAIN.
  - DRAIN: cnt decrements while uart_tx==1 and reloads on uart_tx==0. At cnt==0 with uart_tx==1 → COOLDOWN; cnt=COOLDOWN_CYCLES-1; soc_resetn=0 in the same cycle.
  - COOLDOWN: soc_resetn=0, running=0; cnt decrements, ignoring cts. At cnt==0 → OFF; cnt=WAKE_CYCLES-1.
- poweroff_rq deasserting during DRAIN does not abort the drain.
- soc_resetn and running are registered outputs: a state change becomes visible on the following cycle.
- cts held low continuously through COOLDOWN re-wakes after exactly COOLDOWN_CYCLES+WAKE_CYCLES cycles.
- Reset asserted mid-sequence from any state returns immediately to the reset values above.

Optional Feature:
- PWRSEQ_WDT_EN, with parameter WDT_CYCLES (default 65535, ≤ 2^CNT_W-1):
  - A separate watchdog counter reloads on RST_HOLD→RUN and on each wdt_kick in RUN.
  - On expiry in RUN: wdt_fired<=1 (sticky until reset), then → DRAIN exactly as for poweroff_rq.
  - The counter is frozen outside RUN.
- Without the macro: no watchdog counter, no wdt_kick port, wdt_fired tied 0.

Decomposition:
- Package pwr_seq_pkg: state enum (OFF, RST_HOLD, RUN, DRAIN, COOLDOWN, one-hot encoding) and the default cycle constants.
- Sub-module sync2: a parameterized 2-flop synchronizer with a reset-value parameter, instantiated for uart_cts and dfu.

Test Plan:
- Wake debounce: cts low 15 cycles, high 1, low 16 (WAKE_CYCLES=16) → wake only after the second run. soc_resetn rises exactly 2+16+32 cycles after that run starts; wake_count=1.
- DFU latch: dfu=1 at acceptance, toggled to 0 during RUN → dfu_mode stays 1 until the next wake.
- Drain: poweroff_rq in RUN, uart_tx toggling low every 40 cycles for 200 cycles then high → soc_resetn drops 64 cycles after the last low; running stays 1 throughout the drain.
- Cooldown: cts held low through poweroff → next wake accepted after exactly 256+16 cycles; wake_count increments.
- Async reset in DRAIN: assert reset mid-count → soc_resetn=0, state OFF, wake_count=0 without a clock edge.
- PWRSEQ_WDT_EN, WDT_CYCLES=100: no kicks → wdt_fired=1 at cycle 100 of RUN and DRAIN is entered; kicks every 50 cycles → never fires.

Source files
------------

// File: rtl/pwr_seq_pkg.sv
// Shared types and default timing constants for the pwr_seq power/reset sequencer.
// The watchdog default is only used when PWRSEQ_WDT_EN is defined.
package pwr_seq_pkg;

  typedef enum logic [4:0] {
    ST_OFF      = 5'b00001,
    ST_RST_HOLD = 5'b00010,
    ST_RUN      = 5'b00100,
    ST_DRAIN    = 5'b01000,
    ST_COOLDOWN = 5'b10000
  } pwr_state_e;

  localparam int unsigned WAKE_CYCLES_DEF     = 32'd16;
  localparam int unsigned RST_CYCLES_DEF      = 32'd32;
  localparam int unsigned DRAIN_CYCLES_DEF    = 32'd64;
  localparam int unsigned COOLDOWN_CYCLES_DEF = 32'd256;
  localparam int unsigned CNT_W_DEF           = 32'd16;
  localparam int unsigned WDT_CYCLES_DEF      = 32'd65535;

  // A cycle count must be loadable as (cycles-1) into a cnt_w-bit down-counter.
  function automatic bit cycles_ok(input int unsigned cycles, input int unsigned cnt_w);
    return (cycles >= 32'd1) && (64'(cycles) < (64'd1 << cnt_w));
  endfunction

endpackage

// File: rtl/pwr_seq_sync2.sv
// Two-flop synchronizer with a configurable reset value, used for the
// asynchronous board-level inputs of pwr_seq.
module sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Capture and re-register the asynchronous input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pwr_seq.sv
// Power/reset sequencer: debounced wake, stretched SoC reset, UART drain and cooldown.
// Optional watchdog (wdt_kick port, WDT_CYCLES parameter) is enabled by PWRSEQ_WDT_EN.
module pwr_seq
  import pwr_seq_pkg::*;
#(
  parameter int unsigned CNT_W           = CNT_W_DEF,
  parameter int unsigned WAKE_CYCLES     = WAKE_CYCLES_DEF,
  parameter int unsigned RST_CYCLES      = RST_CYCLES_DEF,
  parameter int unsigned DRAIN_CYCLES    = DRAIN_CYCLES_DEF,
  parameter int unsigned COOLDOWN_CYCLES = COOLDOWN_CYCLES_DEF
`ifdef PWRSEQ_WDT_EN
  , parameter int unsigned WDT_CYCLES    = WDT_CYCLES_DEF
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_cts,
  input  logic       dfu,
  input  logic       uart_tx,
  input  logic       poweroff_rq,
`ifdef PWRSEQ_WDT_EN
  input  logic       wdt_kick,
`endif
  output logic       soc_resetn,
  output logic       running,
  output logic       dfu_mode,
  output logic [7:0] wake_count,
  output logic       wdt_fired
);

  localparam bit CFG_OK = cycles_ok(WAKE_CYCLES, CNT_W) && cycles_ok(RST_CYCLES, CNT_W)
                       && cycles_ok(DRAIN_CYCLES, CNT_W) && cycles_ok(COOLDOWN_CYCLES, CNT_W)
`ifdef PWRSEQ_WDT_EN
                       && cycles_ok(WDT_CYCLES, CNT_W)
`endif
                       ;

  if (!CFG_OK) begin : g_cfg_err
    $error("pwr_seq: every *_CYCLES parameter must be >= 1 and < 2**CNT_W");
  end

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] WAKE_LD  = CNT_W'(WAKE_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] RST_LD   = CNT_W'(RST_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] DRAIN_LD = CNT_W'(DRAIN_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] COOL_LD  = CNT_W'(COOLDOWN_CYCLES - 32'd1);

  logic cts_s;
  logic dfu_s;

  sync2 #(.RST_VAL(1'b1)) u_sync_cts (.clk(clk), .reset(reset), .d(uart_cts), .q(cts_s));
  sync2 #(.RST_VAL(1'b0)) u_sync_dfu (.clk(clk), .reset(reset), .d(dfu),      .q(dfu_s));

  pwr_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dfu_mode_q, dfu_mode_d;
  logic [7:0]       wake_count_q, wake_count_d;
  logic             soc_resetn_q, running_q, run_out_d;
  logic             wdt_expire;
  logic             cnt_zero;

`ifdef PWRSEQ_WDT_EN
  localparam logic [CNT_W-1:0] WDT_LD = CNT_W'(WDT_CYCLES - 32'd1);
  logic [CNT_W-1:0] wdt_cnt_q, wdt_cnt_d;
  logic             wdt_fired_q, wdt_fired_d;
`endif

  // Next-state, counter and latched-output logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    dfu_mode_d   = dfu_mode_q;
    wake_count_d = wake_count_q;
    wdt_expire   = 1'b0;
    cnt_zero     = (cnt_q == CNT_ZERO);

`ifdef PWRSEQ_WDT_EN
    wdt_cnt_d = wdt_cnt_q;
    if (state_q == ST_RUN) begin
      if (wdt_kick) begin
        wdt_cnt_d = WDT_LD;
      end else if (wdt_cnt_q == CNT_ZERO) begin
        wdt_expire = 1'b1;
      end else begin
        wdt_cnt_d = wdt_cnt_q - CNT_ONE;
      end
    end else if ((state_q == ST_RST_HOLD) && cnt_zero) begin
      wdt_cnt_d = WDT_LD;
    end else begin
      wdt_cnt_d = wdt_cnt_q;
    end
    wdt_fired_d = wdt_fired_q | wdt_expire;
`endif

    case (state_q)
      ST_OFF: begin
        if (cts_s) begin
          cnt_d = WAKE_LD;
        end else if (cnt_zero) begin
          state_d      = ST_RST_HOLD;
          cnt_d        = RST_LD;
          dfu_mode_d   = dfu_s;
          wake_count_d = wake_count_q + 8'd1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_RST_HOLD: begin
        if (cnt_zero) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_RUN: begin
        if (poweroff_rq || wdt_expire) begin
          state_d = ST_DRAIN;
          cnt_d   = DRAIN_LD;
        end else begin
          cnt_d = cnt_q;
        end
      end
      // Only an unbroken run of idle-high TX cycles counts as drained.
      ST_DRAIN: begin
        if (!uart_tx) begin
          cnt_d = DRAIN_LD;
        end else if (cnt_zero) begin
          state_d = ST_COOLDOWN;
          cnt_d   = COOL_LD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_COOLDOWN: begin
        if (cnt_zero) begin
          state_d = ST_OFF;
          cnt_d   = WAKE_LD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = ST_OFF;
        cnt_d   = WAKE_LD;
      end
    endcase

    // Outputs follow the state one cycle late, except the drop into cooldown is immediate.
    run_out_d = (state_q == ST_RUN) || ((state_q == ST_DRAIN) && (state_d == ST_DRAIN));
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_OFF;
      cnt_q        <= WAKE_LD;
      dfu_mode_q   <= 1'b0;
      wake_count_q <= 8'd0;
      soc_resetn_q <= 1'b0;
      running_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dfu_mode_q   <= dfu_mode_d;
      wake_count_q <= wake_count_d;
      soc_resetn_q <= run_out_d;
      running_q    <= run_out_d;
    end
  end

`ifdef PWRSEQ_WDT_EN
  // Watchdog counter and sticky expiry flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wdt_cnt_q   <= WDT_LD;
      wdt_fired_q <= 1'b0;
    end else begin
      wdt_cnt_q   <= wdt_cnt_d;
      wdt_fired_q <= wdt_fired_d;
    end
  end

  assign wdt_fired = wdt_fired_q;
`else
  assign wdt_fired = 1'b0;
`endif

  assign soc_resetn = soc_resetn_q;
  assign running    = running_q;
  assign dfu_mode   = dfu_mode_q;
  assign wake_count = wake_count_q;

endmodule

// File: tb/tb_pwr_seq.sv
// Directed, scoreboard-driven bench for pwr_seq; watchdog steps run when PWRSEQ_WDT_EN is defined.
module tb_pwr_seq;
  import pwr_seq_pkg::*;

  logic       clk;
  logic       reset;
  logic       uart_cts;
  logic       dfu;
  logic       uart_tx;
  logic       poweroff_rq;
  logic       wdt_kick;
  logic       soc_resetn;
  logic       running;
  logic       dfu_mode;
  logic [7:0] wake_count;
  logic       wdt_fired;

  localparam int SIG_SOC = 0;
  localparam int SIG_RUN = 1;
  localparam int SIG_DFU = 2;
  localparam int SIG_WC  = 3;
  localparam int SIG_WDT = 4;

  typedef struct {
    string      tag;
    int         cyc;
    int         sig;
    logic [7:0] val;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   s, L, C, R;

`ifdef PWRSEQ_WDT_EN
  pwr_seq #(.WDT_CYCLES(100)) dut (
    .clk(clk), .reset(reset), .uart_cts(uart_cts), .dfu(dfu), .uart_tx(uart_tx),
    .poweroff_rq(poweroff_rq), .wdt_kick(wdt_kick), .soc_resetn(soc_resetn),
    .running(running), .dfu_mode(dfu_mode), .wake_count(wake_count), .wdt_fired(wdt_fired)
  );
`else
  pwr_seq dut (
    .clk(clk), .reset(reset), .uart_cts(uart_cts), .dfu(dfu), .uart_tx(uart_tx),
    .poweroff_rq(poweroff_rq), .soc_resetn(soc_resetn),
    .running(running), .dfu_mode(dfu_mode), .wake_count(wake_count), .wdt_fired(wdt_fired)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] observe(input int sig);
    case (sig)
      SIG_SOC: return {7'd0, soc_resetn};
      SIG_RUN: return {7'd0, running};
      SIG_DFU: return {7'd0, dfu_mode};
      SIG_WC:  return wake_count;
      SIG_WDT: return {7'd0, wdt_fired};
      default: return 8'hxx;
    endcase
  endfunction

  task automatic push(input string tag, input int at, input int sig, input logic [7:0] val);
    exp_t e;
    e.tag = tag;
    e.cyc = at;
    e.sig = sig;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Compare every expectation due after this cycle's active edge.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        check(sb[i].tag, observe(sb[i].sig), sb[i].val);
        sb.delete(i);
      end else if (sb[i].cyc < cyc) begin
        n_checks++;
        n_errors++;
        $error("FAIL %s: expectation for cycle %0d never sampled", sb[i].tag, sb[i].cyc);
        sb.delete(i);
      end
    end
  end

  initial begin
    reset = 1'b1; uart_cts = 1'b1; dfu = 1'b0; uart_tx = 1'b1; poweroff_rq = 1'b0; wdt_kick = 1'b0;
    #1;
    check("rst_soc_resetn", {7'd0, soc_resetn}, 8'd0);
    check("rst_running",    {7'd0, running},    8'd0);
    check("rst_wake_count", wake_count,         8'd0);
    check("rst_wdt_fired",  {7'd0, wdt_fired},  8'd0);
    adv(2);
    reset = 1'b0;
    adv(3);

    // Interrupted debounce run (15 low cycles) must not wake.
    uart_cts = 1'b0;
    adv(15);
    uart_cts = 1'b1;
    adv(1);
    dfu = 1'b1;
    uart_cts = 1'b0;
    s = cyc + 1;
    push("debounce_no_wake",   s + 16, SIG_WC,  8'd0);
    push("wake_count_1",       s + 17, SIG_WC,  8'd1);
    push("dfu_latched",        s + 17, SIG_DFU, 8'd1);
    push("resetn_still_low",   s + 49, SIG_SOC, 8'd0);
    push("resetn_rise_at_50",  s + 50, SIG_SOC, 8'd1);
    push("running_at_50",      s + 50, SIG_RUN, 8'd1);
    adv(60);
    dfu = 1'b0;
    push("dfu_held_in_run", cyc + 10, SIG_DFU, 8'd1);
    adv(20);

    // Poweroff with TX activity every 40 cycles; poweroff_rq drops immediately.
    poweroff_rq = 1'b1;
    adv(1);
    poweroff_rq = 1'b0;
    repeat (5) begin
      adv(39);
      uart_tx = 1'b0;
      adv(1);
      uart_tx = 1'b1;
      L = cyc;
      push("running_in_drain", L, SIG_RUN, 8'd1);
    end
    push("drain_resetn_hold", L + 63, SIG_SOC, 8'd1);
    push("drain_running_hold", L + 63, SIG_RUN, 8'd1);
    push("drain_resetn_drop", L + 64, SIG_SOC, 8'd0);
    push("drain_running_drop", L + 64, SIG_RUN, 8'd0);

    // cts stays low through cooldown: re-wake after exactly 256+16 cycles.
    C = L + 64;
    push("cool_no_wake_yet", C + 271, SIG_WC,  8'd1);
    push("cool_dfu_still_1", C + 271, SIG_DFU, 8'd1);
    push("cool_wake_count2", C + 272, SIG_WC,  8'd2);
    push("cool_dfu_relatch", C + 272, SIG_DFU, 8'd0);
    push("rewake_resetn_low", C + 304, SIG_SOC, 8'd0);
    push("rewake_resetn_up",  C + 305, SIG_SOC, 8'd1);
    adv(C + 320 - cyc);

    // Async reset in the middle of a drain.
    poweroff_rq = 1'b1;
    adv(1);
    poweroff_rq = 1'b0;
    push("running_before_rst", cyc + 10, SIG_RUN, 8'd1);
    adv(20);
    reset = 1'b1;
    #1;
    check("arst_soc_resetn", {7'd0, soc_resetn}, 8'd0);
    check("arst_running",    {7'd0, running},    8'd0);
    check("arst_wake_count", wake_count,         8'd0);
    check("arst_dfu_mode",   {7'd0, dfu_mode},   8'd0);
    check("arst_state_off",  {3'd0, dut.state_q}, {3'd0, ST_OFF});
    check("sb_drained",      8'(sb.size()),      8'd0);
    adv(2);
    reset = 1'b0;

`ifdef PWRSEQ_WDT_EN
    // No kicks: watchdog fires at RUN cycle 100 and drains.
    s = cyc + 1;
    R = s + 49;
    push("wdt_quiet_99",    R + 99,  SIG_WDT, 8'd0);
    push("wdt_fire_100",    R + 100, SIG_WDT, 8'd1);
    push("wdt_drain_run",   R + 100, SIG_RUN, 8'd1);
    push("wdt_drain_hold",  R + 163, SIG_SOC, 8'd1);
    push("wdt_drain_drop",  R + 164, SIG_SOC, 8'd0);
    push("wdt_sticky",      R + 200, SIG_WDT, 8'd1);
    adv(R + 210 - cyc);

    // Kicks every 50 cycles keep the watchdog quiet.
    reset = 1'b1;
    adv(1);
    reset = 1'b0;
    s = cyc + 1;
    R = s + 49;
    adv(R + 1 - cyc);
    repeat (6) begin
      adv(49);
      wdt_kick = 1'b1;
      adv(1);
      wdt_kick = 1'b0;
      push("wdt_kicked_quiet", cyc + 20, SIG_WDT, 8'd0);
    end
    push("wdt_kicked_running", cyc + 20, SIG_RUN, 8'd1);
    adv(30);
    check("sb_drained_wdt", 8'(sb.size()), 8'd0);
`endif

    adv(2);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
